// File: rtl/myproject_mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// myproject_mul_share_ctrl
//
// Shares one unsigned 16x14 -> 30-bit multiplier among NUM_REQ requesters.
// Each cycle a round-robin arbiter picks at most one valid requester. Its
// operands are multiplied and pushed into a MUL_STAGES-deep pipeline. The
// last stage presents the product, tagged with the requester index, on a
// single valid/ready result port.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   MUL_STAGES  pipeline registers from operand acceptance to result (1..4)
//   ID_WIDTH    requester tag width, clog2(NUM_REQ)
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]      requester i presents operands
//   req_ready  out  [NUM_REQ]      requester i accepted this cycle (one-hot or 0)
//   req_a      in   [NUM_REQ*16]   packed operand A, requester i at [16i+15:16i]
//   req_b      in   [NUM_REQ*14]   packed operand B, requester i at [14i+13:14i]
//   res_valid  out                 result available
//   res_ready  in                  downstream accepts the result
//   res_data   out  [30]           product a*b
//   res_id     out  [ID_WIDTH]     requester that issued the operands
//   busy       out                 any pipeline stage holds a valid entry
//   op_count   out  [16]           completed result handshakes, wraps at 2^16
// -----------------------------------------------------------------------------
module myproject_mul_share_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int MUL_STAGES = 1,
    parameter int ID_WIDTH   = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*16-1:0]  req_a,
    input  logic [NUM_REQ*14-1:0]  req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [29:0]            res_data,
    output logic [ID_WIDTH-1:0]    res_id,
    output logic                   busy,
    output logic [15:0]            op_count
);

    // Reduce an arbitrary non-negative integer to a requester index.
    function automatic logic [ID_WIDTH-1:0] idx_wrap(input int v);
        return ID_WIDTH'(v % NUM_REQ);
    endfunction

    // -------------------------------------------------------------------------
    // Operand unpacking
    // -------------------------------------------------------------------------
    logic [15:0] a_arr [NUM_REQ];
    logic [13:0] b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[16*gi +: 16];
            assign b_arr[gi] = req_b[14*gi +: 14];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin arbiter
    // -------------------------------------------------------------------------
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] ptr_d;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                grant_found;
    logic                adv;
    logic                hs;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!grant_found && req_valid[idx_wrap(int'(ptr_q) + off)]) begin
                grant_found = 1'b1;
                grant_idx   = idx_wrap(int'(ptr_q) + off);
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // The whole pipeline moves only when the output slot is empty or being
    // drained, so a stalled result also blocks new acceptances.
    assign adv       = !res_valid || res_ready;
    assign req_ready = grant & {NUM_REQ{adv && !ap_rst}};
    assign hs        = |req_ready;

    // Pointer moves past the winner only on an actual handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = idx_wrap(int'(grant_idx) + 1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shared multiplier
    // -------------------------------------------------------------------------
    logic [15:0] a_sel;
    logic [13:0] b_sel;
    logic [29:0] product;

    assign a_sel   = a_arr[grant_idx];
    assign b_sel   = b_arr[grant_idx];
    assign product = {14'd0, a_sel} * {16'd0, b_sel};

    // -------------------------------------------------------------------------
    // Result pipeline: every stage shifts together on adv, holds otherwise.
    // Bubbles are kept so that latency stays fixed at MUL_STAGES.
    // -------------------------------------------------------------------------
    logic [MUL_STAGES-1:0] stage_valid_vec;

    generate
        for (gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
            logic                valid_q;
            logic                valid_d;
            logic [ID_WIDTH-1:0] id_q;
            logic [ID_WIDTH-1:0] id_d;
            logic [29:0]         prod_q;
            logic [29:0]         prod_d;
            logic                in_valid;
            logic [ID_WIDTH-1:0] in_id;
            logic [29:0]         in_prod;

            if (gi == 0) begin : g_head
                // Non-handshake cycles insert a zeroed bubble.
                assign in_valid = hs;
                assign in_id    = hs ? grant_idx : '0;
                assign in_prod  = hs ? product : '0;
            end else begin : g_body
                assign in_valid = g_stage[gi-1].valid_q;
                assign in_id    = g_stage[gi-1].id_q;
                assign in_prod  = g_stage[gi-1].prod_q;
            end

            always_comb begin
                valid_d = valid_q;
                id_d    = id_q;
                prod_d  = prod_q;
                if (adv) begin
                    valid_d = in_valid;
                    id_d    = in_id;
                    prod_d  = in_prod;
                end
            end

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    valid_q <= 1'b0;
                    id_q    <= '0;
                    prod_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    id_q    <= id_d;
                    prod_q  <= prod_d;
                end
            end

            assign stage_valid_vec[gi] = valid_q;
        end
    endgenerate

    assign res_valid = g_stage[MUL_STAGES-1].valid_q;
    assign res_id    = g_stage[MUL_STAGES-1].id_q;
    assign res_data  = g_stage[MUL_STAGES-1].prod_q;
    assign busy      = |stage_valid_vec;

    // -------------------------------------------------------------------------
    // Completed-result counter (wraps naturally at 16 bits)
    // -------------------------------------------------------------------------
    logic [15:0] op_count_q;
    logic [15:0] op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (res_valid && res_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;

endmodule

// File: tb/tb_myproject_mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_myproject_mul_share_ctrl
//
// Directed bench for myproject_mul_share_ctrl with NUM_REQ=4, MUL_STAGES=3.
// Inputs change 1 time unit after the rising edge; outputs are checked one
// more unit later, so registered outputs reflect the just-taken edge and
// req_ready reflects the inputs of the current cycle.
// -----------------------------------------------------------------------------
module tb_myproject_mul_share_ctrl;

    localparam int NR = 4;
    localparam int MS = 3;
    localparam int IW = 2;

    logic            ap_clk    = 1'b0;
    logic            ap_rst    = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*16-1:0] req_a    = '0;
    logic [NR*14-1:0] req_b    = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [29:0]     res_data;
    logic [IW-1:0]   res_id;
    logic            busy;
    logic [15:0]     op_count;

    int checks = 0;
    int errors = 0;

    myproject_mul_share_ctrl #(
        .NUM_REQ    (NR),
        .MUL_STAGES (MS),
        .ID_WIDTH   (IW)
    ) u_dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [13:0] b);
        req_a[16*i +: 16] = a;
        req_b[14*i +: 14] = b;
    endtask

    // Requester-side protocol: a pending request stays valid and stable until
    // accepted, and at most one requester is accepted per cycle.
    logic [NR-1:0]    pend_q = '0;
    logic [NR*16-1:0] prev_a = '0;
    logic [NR*14-1:0] prev_b = '0;

    always @(negedge ap_clk) begin
        for (int i = 0; i < NR; i++) begin
            if (pend_q[i]) begin
                assert (req_valid[i] && req_a[16*i +: 16] === prev_a[16*i +: 16]
                        && req_b[14*i +: 14] === prev_b[14*i +: 14]) else begin
                    errors++;
                    $error("FAIL req_hold_%0d observed valid=%0b a=%0h b=%0h expected valid=1 a=%0h b=%0h",
                           i, req_valid[i], req_a[16*i +: 16], req_b[14*i +: 14],
                           prev_a[16*i +: 16], prev_b[14*i +: 14]);
                end
            end
        end
        assert ($onehot0(req_ready)) else begin
            errors++;
            $error("FAIL ready_onehot observed=%0h expected at most one bit", req_ready);
        end
        pend_q <= req_valid & ~req_ready;
        prev_a <= req_a;
        prev_b <= req_b;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        ap_rst    = 1'b1;
        res_ready = 1'b1;
        repeat (3) cyc();
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_op_count",  op_count,  0);
        chk("rst_res_data",  res_data,  0);
        chk("rst_res_id",    res_id,    0);
        ap_rst = 1'b0;
        cyc();

        // ---------------- all requesters, ptr=0 ----------------
        for (int i = 0; i < NR; i++) set_op(i, 16'(i + 1), 14'h10);
        for (int t = 0; t < 7; t++) begin
            req_valid = (t < 4) ? 4'(4'hF << t) : 4'h0;
            #1;
            chk("all_ready", req_ready, (t < 4) ? (1 << t) : 0);
            chk("all_res_valid", res_valid, (t >= 3) ? 1 : 0);
            if (t >= 3) begin
                chk("all_res_id",   res_id,   t - 3);
                chk("all_res_data", res_data, (t - 2) * 16);
            end
            cyc();
        end
        #1;
        chk("all_op_count", op_count, 4);
        chk("all_busy",     busy,     0);

        // ---------------- single request, max operands ----------------
        set_op(0, 16'hFFFF, 14'h3FFF);
        req_valid = 4'b0001;
        #1;
        chk("max_ready", req_ready, 4'b0001);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("max_busy",      busy,      1);
        chk("max_early_vld", res_valid, 0);
        cyc();
        cyc();
        #1;
        chk("max_res_valid", res_valid, 1);
        chk("max_res_data",  res_data,  32'h3FFEC001);
        chk("max_res_id",    res_id,    0);
        chk("max_cnt_pre",   op_count,  4);
        cyc();
        #1;
        chk("max_cnt_post",  op_count,  5);
        chk("max_idle",      busy,      0);

        // ---------------- fairness between requesters 1 and 3 ----------------
        set_op(1, 16'h0100, 14'h0002);
        set_op(3, 16'h0003, 14'h0005);
        for (int t = 0; t < 11; t++) begin
            req_valid = (t < 7) ? 4'b1010 : ((t == 7) ? 4'b1000 : 4'b0000);
            #1;
            if (t < 8) chk("fair_ready", req_ready, (t % 2 == 0) ? 4'b0010 : 4'b1000);
            else       chk("fair_ready_idle", req_ready, 0);
            chk("fair_res_valid", res_valid, (t >= 3) ? 1 : 0);
            if (t >= 3) begin
                chk("fair_res_id",   res_id,   ((t - 3) % 2 == 0) ? 1 : 3);
                chk("fair_res_data", res_data, ((t - 3) % 2 == 0) ? 32'h200 : 32'hF);
            end
            cyc();
        end
        #1;
        chk("fair_op_count", op_count, 13);

        // ---------------- backpressure ----------------
        res_ready = 1'b0;
        set_op(0, 16'd2, 14'd3);
        req_valid = 4'b0001;
        #1;
        chk("bp_fill0", req_ready, 4'b0001);
        cyc();
        set_op(1, 16'd4, 14'd5);
        req_valid = 4'b0010;
        #1;
        chk("bp_fill1", req_ready, 4'b0010);
        cyc();
        set_op(2, 16'd6, 14'd7);
        req_valid = 4'b0100;
        #1;
        chk("bp_fill2", req_ready, 4'b0100);
        cyc();
        set_op(3, 16'd8, 14'd9);
        req_valid = 4'b1000;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_stall_ready", req_ready, 0);
            chk("bp_stall_valid", res_valid, 1);
            chk("bp_stall_data",  res_data,  6);
            chk("bp_stall_id",    res_id,    0);
            chk("bp_stall_cnt",   op_count,  13);
            cyc();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_rel_ready", req_ready, 4'b1000);
        chk("bp_drain0_id",   res_id,   0);
        chk("bp_drain0_data", res_data, 6);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("bp_drain1_valid", res_valid, 1);
        chk("bp_drain1_id",    res_id,    1);
        chk("bp_drain1_data",  res_data,  20);
        cyc();
        #1;
        chk("bp_drain2_id",   res_id,   2);
        chk("bp_drain2_data", res_data, 42);
        cyc();
        #1;
        chk("bp_new_id",   res_id,   3);
        chk("bp_new_data", res_data, 72);
        cyc();
        #1;
        chk("bp_end_valid", res_valid, 0);
        chk("bp_op_count",  op_count,  17);

        // ---------------- reset mid-flight ----------------
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(i, 16'(i + 1), 14'd1);
            req_valid = 4'(1 << i);
            cyc();
        end
        set_op(3, 16'd4, 14'd1);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        ap_rst    = 1'b1;
        #1;
        chk("mid_busy_before", busy,      1);
        chk("mid_rst_ready",   req_ready, 0);
        cyc();
        ap_rst = 1'b0;
        #1;
        chk("mid_res_valid", res_valid, 0);
        chk("mid_busy",      busy,      0);
        chk("mid_op_count",  op_count,  0);
        chk("mid_res_data",  res_data,  0);
        chk("mid_first_gnt", req_ready, 4'b0001);
        cyc();
        req_valid = 4'b1110;
        #1;
        chk("mid_gnt1", req_ready, 4'b0010);
        cyc();
        req_valid = 4'b1100;
        #1;
        chk("mid_gnt2", req_ready, 4'b0100);
        cyc();
        req_valid = 4'b1000;
        #1;
        chk("mid_gnt3", req_ready, 4'b1000);
        cyc();
        req_valid = 4'b0000;
        repeat (4) cyc();
        #1;
        chk("mid_op_count_end", op_count, 4);
        chk("mid_idle",         busy,     0);

        // ---------------- counter wrap and zero operand ----------------
        set_op(0, 16'd3, 14'd2);
        req_valid = 4'b0001;
        repeat (65531) cyc();
        req_valid = 4'b0000;
        repeat (5) cyc();
        #1;
        chk("wrap_preload", op_count, 16'hFFFF);
        set_op(2, 16'h0000, 14'h1234);
        req_valid = 4'b0100;
        #1;
        chk("zero_ready", req_ready, 4'b0100);
        cyc();
        req_valid = 4'b0000;
        cyc();
        cyc();
        #1;
        chk("zero_res_valid", res_valid, 1);
        chk("zero_res_data",  res_data,  0);
        chk("zero_res_id",    res_id,    2);
        cyc();
        #1;
        chk("wrap_op_count", op_count, 0);
        chk("wrap_idle",     res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
